// File: rtl/tp84_audio_filter.sv
// tp84_audio_filter: decimates the core's 16-bit sound to a 48 kHz stream,
// then runs an optional low-pass, optional DC blocker, saturation and mute.
module tp84_audio_filter #(
  parameter int DIV       = 1024,
  parameter int LPF_SHIFT = 2,
  parameter int DCB_SHIFT = 10
) (
  input  logic               clk_49m,
  input  logic               reset,
  input  logic signed [15:0] sound_in,
  input  logic               lpf_en,
  input  logic               dcb_en,
  input  logic               mute,
  output logic signed [15:0] sound_out,
  output logic               sample_strobe
);

  localparam int CW = $clog2(DIV);
  localparam int LW = 16 + LPF_SHIFT;
  localparam int DW = 16 + DCB_SHIFT;

  logic [CW-1:0]        cnt;
  logic                 tick;

  logic signed [15:0]   x;
  logic                 v0;

  logic signed [LW-1:0] lp_acc;
  logic signed [LW-1:0] lp_x;
  logic signed [LW-1:0] lp_shl;
  logic signed [LW-1:0] lp_dec;
  logic signed [LW-1:0] lp_upd;
  logic signed [LW-1:0] lp_next;
  logic signed [15:0]   y_next;
  logic signed [15:0]   y_lp;
  logic                 v1;

  logic signed [DW-1:0] dc_acc;
  logic signed [DW-1:0] dc_next;
  logic signed [15:0]   dc_m;
  logic signed [16:0]   y_ext;
  logic signed [16:0]   d_blk;
  logic signed [16:0]   d_next;
  logic signed [16:0]   d;
  logic                 v2;

  logic signed [15:0]   d_sat;

  assign tick = (cnt == CW'(DIV - 1));

  // Sample divider: free-running 0..DIV-1
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  // Stage 0: capture the decimated input sample
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      x  <= '0;
      v0 <= 1'b0;
    end else begin
      v0 <= tick;
      if (tick) x <= sound_in;
    end
  end

  // Low-pass update; accumulator holds y_lp scaled by 2^LPF_SHIFT
  always_comb begin
    lp_x    = {{LPF_SHIFT{x[15]}}, x};
    lp_shl  = {x, {LPF_SHIFT{1'b0}}};
    lp_dec  = lp_acc >>> LPF_SHIFT;
    lp_upd  = lp_acc + lp_x - lp_dec;
    lp_next = lpf_en ? lp_upd : lp_shl;
    y_next  = lp_next[LW-1:LPF_SHIFT];
  end

  // Stage 1: low-pass register
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      lp_acc <= '0;
      y_lp   <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= v0;
      if (v0) begin
        lp_acc <= lp_next;
        y_lp   <= y_next;
      end
    end
  end

  // DC blocker: subtract the running mean tracked by dc_acc
  always_comb begin
    y_ext   = {y_lp[15], y_lp};
    dc_m    = dc_acc[DW-1:DCB_SHIFT];
    d_blk   = y_ext - {dc_m[15], dc_m};
    d_next  = dcb_en ? d_blk : y_ext;
    dc_next = '0;
    if (dcb_en) dc_next = dc_acc + {{(DW-17){d_blk[16]}}, d_blk};
  end

  // Stage 2: DC blocker register
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      dc_acc <= '0;
      d      <= '0;
      v2     <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        dc_acc <= dc_next;
        d      <= d_next;
      end
    end
  end

  // Clip the 17-bit difference to the 16-bit range
  always_comb begin
    d_sat = d[15:0];
    if (d[16] != d[15]) d_sat = d[16] ? 16'sh8000 : 16'sh7fff;
  end

  // Stage 3: output register, mute gate and strobe
  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      sound_out     <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= v2;
      if (v2) sound_out <= mute ? 16'sh0000 : d_sat;
    end
  end

endmodule

// File: tb/tb_tp84_audio_filter.sv
// tb_tp84_audio_filter: randomized and directed checks of the audio filter
// against an integer reference model of the filter equations.
module tb_tp84_audio_filter;

  localparam int DIV = 6;
  localparam int LS  = 2;
  localparam int DS  = 10;

  logic               clk_49m = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] sound_in = '0;
  logic               lpf_en = 1'b0;
  logic               dcb_en = 1'b0;
  logic               mute = 1'b0;
  logic signed [15:0] sound_out;
  logic               sample_strobe;

  int checks = 0;
  int errors = 0;
  int m_lp = 0;
  int m_dc = 0;

  tp84_audio_filter #(
    .DIV(DIV),
    .LPF_SHIFT(LS),
    .DCB_SHIFT(DS)
  ) dut (
    .clk_49m(clk_49m),
    .reset(reset),
    .sound_in(sound_in),
    .lpf_en(lpf_en),
    .dcb_en(dcb_en),
    .mute(mute),
    .sound_out(sound_out),
    .sample_strobe(sample_strobe)
  );

  always #5 clk_49m = ~clk_49m;

  function automatic int fdiv(int a, int s);
    int p;
    p = 1 << s;
    if (a >= 0) return a / p;
    return -((-a + p - 1) / p);
  endfunction

  function automatic int model(int xin, bit le, bit de, bit mu);
    int y;
    int m;
    int dd;
    if (le) begin
      m_lp = m_lp + xin - fdiv(m_lp, LS);
      y = fdiv(m_lp, LS);
    end else begin
      m_lp = xin * (1 << LS);
      y = xin;
    end
    m = fdiv(m_dc, DS);
    if (de) begin
      dd = y - m;
      m_dc = m_dc + dd;
    end else begin
      dd = y;
      m_dc = 0;
    end
    if (dd > 32767) dd = 32767;
    if (dd < -32768) dd = -32768;
    return mu ? 0 : dd;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_49m);
    #1;
    reset = 1'b0;
    m_lp = 0;
    m_dc = 0;
  endtask

  task automatic next_sample(input int s, input bit le, input bit de,
                             input bit mu, output int got);
    int n;
    sound_in = 16'(s);
    lpf_en = le;
    dcb_en = de;
    mute = mu;
    n = 0;
    do begin
      @(posedge clk_49m);
      #1;
      n++;
    end while (!sample_strobe && n < 4 * DIV);
    got = sound_out;
    if (!sample_strobe) begin
      checks++;
      errors++;
      $display("FAIL strobe_timeout got none required within %0d", 4 * DIV);
    end
  endtask

  task automatic test_reset();
    int got;
    int first;
    do_reset();
    next_sample(1234, 0, 0, 0, got);
    next_sample(1234, 0, 0, 0, got);
    checks++;
    if (got !== 1234) begin
      errors++;
      $display("FAIL pre_reset_out got %0d required 1234", got);
    end
    @(posedge clk_49m);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (sound_out !== 16'sd0 || sample_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got %0d/%0b required 0/0",
               sound_out, sample_strobe);
    end
    @(posedge clk_49m);
    #1;
    reset = 1'b0;
    m_lp = 0;
    m_dc = 0;
    first = 0;
    for (int k = 1; k <= DIV + 3; k++) begin
      @(posedge clk_49m);
      #1;
      if (sample_strobe && first == 0) first = k;
    end
    checks++;
    if (first !== DIV + 3) begin
      errors++;
      $display("FAIL first_strobe got %0d required %0d", first, DIV + 3);
    end
    checks++;
    if (sound_out !== 16'sd1234) begin
      errors++;
      $display("FAIL first_out got %0d required 1234", sound_out);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    int first;
    next_sample(1234, 0, 0, 0, got);
    repeat (DIV - 3) @(posedge clk_49m);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (sound_out !== 16'sd0 || sample_strobe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_out got %0d/%0b required 0/0",
               sound_out, sample_strobe);
    end
    repeat (2) @(posedge clk_49m);
    #1;
    reset = 1'b0;
    m_lp = 0;
    m_dc = 0;
    first = 0;
    for (int k = 1; k <= DIV + 3; k++) begin
      @(posedge clk_49m);
      #1;
      if (sample_strobe && first == 0) first = k;
    end
    checks++;
    if (first !== DIV + 3) begin
      errors++;
      $display("FAIL reset_mid_strobe got %0d required %0d", first, DIV + 3);
    end
  endtask

  task automatic test_bypass();
    int got;
    int n;
    do_reset();
    next_sample(1234, 0, 0, 0, got);
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(posedge clk_49m);
        #1;
        n++;
      end while (!sample_strobe && n < 4 * DIV);
      checks++;
      if (n !== DIV) begin
        errors++;
        $display("FAIL bypass_period got %0d required %0d", n, DIV);
      end
      checks++;
      if (sound_out !== 16'sd1234) begin
        errors++;
        $display("FAIL bypass_out got %0d required 1234", sound_out);
      end
    end
  endtask

  task automatic test_lpf_step();
    int got;
    int prev;
    bit mono;
    int exp_v[3];
    exp_v = '{2000, 3500, 4625};
    do_reset();
    next_sample(0, 1, 0, 0, got);
    next_sample(0, 1, 0, 0, got);
    for (int i = 0; i < 3; i++) begin
      next_sample(8000, 1, 0, 0, got);
      checks++;
      if (got !== exp_v[i]) begin
        errors++;
        $display("FAIL lpf_step%0d got %0d required %0d", i, got, exp_v[i]);
      end
    end
    prev = got;
    mono = 1'b1;
    for (int i = 0; i < 60; i++) begin
      next_sample(8000, 1, 0, 0, got);
      if (got < prev || got > 8000) mono = 1'b0;
      prev = got;
    end
    checks++;
    if (!mono) begin
      errors++;
      $display("FAIL lpf_monotonic got 0 required 1");
    end
    checks++;
    if (got !== 8000) begin
      errors++;
      $display("FAIL lpf_settle got %0d required 8000", got);
    end
  endtask

  task automatic test_mute();
    int got;
    next_sample(8000, 1, 0, 1, got);
    checks++;
    if (got !== 0) begin
      errors++;
      $display("FAIL mute_on got %0d required 0", got);
    end
    next_sample(8000, 1, 0, 0, got);
    checks++;
    if (got !== 8000) begin
      errors++;
      $display("FAIL mute_off got %0d required 8000", got);
    end
  endtask

  task automatic test_dcb();
    int got;
    int prev;
    int exp;
    bit mono;
    do_reset();
    exp = model(10000, 0, 1, 0);
    next_sample(10000, 0, 1, 0, got);
    checks++;
    if (got !== 10000 || exp !== 10000) begin
      errors++;
      $display("FAIL dcb_first got %0d required 10000", got);
    end
    prev = got;
    mono = 1'b1;
    for (int i = 1; i < 5000; i++) begin
      exp = model(10000, 0, 1, 0);
      next_sample(10000, 0, 1, 0, got);
      if (got > prev || got < 0) mono = 1'b0;
      prev = got;
      checks++;
      if (got !== exp) begin
        errors++;
        if (errors < 10)
          $display("FAIL dcb_model[%0d] got %0d required %0d", i, got, exp);
      end
    end
    checks++;
    if (!mono) begin
      errors++;
      $display("FAIL dcb_monotonic got 0 required 1");
    end
    checks++;
    if (got >= 100 || got <= -100) begin
      errors++;
      $display("FAIL dcb_decay got %0d required |v|<100", got);
    end
  endtask

  task automatic test_sat();
    int got;
    int exp;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      exp = model(32767, 0, 1, 0);
      next_sample(32767, 0, 1, 0, got);
      if (i == 0) begin
        checks++;
        if (got !== 32767) begin
          errors++;
          $display("FAIL sat_hi got %0d required 32767", got);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp = model(-32768, 0, 1, 0);
      next_sample(-32768, 0, 1, 0, got);
      checks++;
      if (got !== exp || got > 0) begin
        errors++;
        $display("FAIL sat_lo%0d got %0d required %0d", i, got, exp);
      end
    end
    exp = model(-32768, 0, 1, 0);
    next_sample(-32768, 0, 1, 0, got);
    checks++;
    if (got !== -32768 && got !== exp) begin
      errors++;
      $display("FAIL sat_clamp got %0d required %0d", got, exp);
    end
  endtask

  task automatic test_random();
    int got;
    int exp;
    int xi;
    bit le;
    bit de;
    bit mu;
    logic signed [15:0] r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = 16'($urandom);
      xi = r;
      le = 1'($urandom);
      de = 1'($urandom);
      mu = ($urandom_range(0, 7) == 0);
      exp = model(xi, le, de, mu);
      next_sample(xi, le, de, mu, got);
      checks++;
      if (got !== exp) begin
        errors++;
        if (errors < 20)
          $display("FAIL random[%0d] got %0d required %0d", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_bypass();
    test_lpf_step();
    test_mute();
    test_dcb();
    test_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
